// File: rtl/mult_booth.sv
// Sequential signed multiplier using radix-2 Booth recoding.
// One Booth step per clock; the full 2*WIDTH-bit product lands in hi/lo
// on the RUN->DONE edge. Handshake: start is sampled only in IDLE.
// busy is high for the WIDTH cycles of RUN. done then pulses for one cycle
// while hi/lo hold the new product.
module mult_booth #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     mcand_q, mcand_d;   // sign-extended multiplicand
  logic [WIDTH:0]     acc_q, acc_d;       // one extra bit so -(-2^(W-1)) fits
  logic [WIDTH-1:0]   q_q, q_d;           // multiplier, shifts out as product low half
  logic               q1_q, q1_d;         // Booth look-behind bit
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Booth step datapath signals
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH-1:0]   q_sh;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_step;

  // State and datapath registers; reset overrides everything, including RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // One Booth add/sub followed by an arithmetic right shift of {acc,Q,q_1}
  always_comb begin
    sum = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + mcand_q;
      2'b10:   sum = acc_q - mcand_q;
      default: sum = acc_q;
    endcase
    acc_sh    = {sum[WIDTH], sum[WIDTH:1]};
    q_sh      = {sum[0], q_q[WIDTH-1:1]};
    cnt_inc   = cnt_q + 1'b1;
    last_step = (cnt_inc == CNT_W'(WIDTH));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath register updates: capture in IDLE, step in RUN, result on the last step
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = {A[WIDTH-1], A};
          acc_d   = '0;
          q_d     = B;
          q1_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_inc;
        if (last_step) begin
          hi_d = acc_sh[WIDTH-1:0];
          lo_d = q_sh;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_booth.sv
// Directed and random checks for mult_booth: reset values, signed products,
// latency, done pulse width, ignored start while busy, mid-run reset and
// back-to-back throughput.
module tb_mult_booth;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int n_checks;
  int n_errors;
  logic [2*W-1:0] last_prod;

  mult_booth #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one multiply at a negedge and follow it to completion.
  // disturb > 0: at that RUN cycle pulse start and change A/B (must be ignored).
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input int disturb);
    int n;
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5) check({tag, "_hold"}, {hi, lo}, last_prod);
      if (n == disturb) begin
        start = 1'b1;
        A = 32'd9;
        B = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(W));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_prod"}, {hi, lo}, exp);
    @(negedge clock);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    last_prod = exp;
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    return sa * sb;
  endfunction

  initial begin
    int done_cyc[3];
    int cyc;
    int k;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks  = 0;
    n_errors  = 0;
    last_prod = '0;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // Directed products
    run_op("p7x3",      32'd7,          32'd3,          64'h0000_0000_0000_0015, 0);
    run_op("pm7x3",     32'hFFFF_FFF9,  32'd3,          64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("pm1xm1",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 0);
    run_op("pminxmin",  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 0);
    run_op("pminx1",    32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000, 0);
    run_op("pzero",     32'd0,          32'h1234_5678,  64'h0000_0000_0000_0000, 0);

    // start while busy is ignored; operands stay latched
    run_op("p5x6_dist", 32'd5,          32'd6,          64'h0000_0000_0000_001E, 10);
    check("idle_after_dist", 64'(busy), 64'd0);
    run_op("p5x6",      32'd5,          32'd6,          64'h0000_0000_0000_001E, 0);

    // Reset in the middle of RUN
    A = 32'd2;
    B = 32'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_state", 64'(dut.state_q), 64'd0);
    last_prod = '0;
    run_op("p4x4",      32'd4,          32'd4,          64'h0000_0000_0000_0010, 0);

    // Back-to-back starts: done-to-done spacing
    A = 32'd3;
    B = 32'hFFFF_FFFE;
    start = 1'b1;
    cyc = 0;
    k = 0;
    while (k < 3 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (done) begin
        done_cyc[k] = cyc;
        k++;
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(k), 64'd3);
    if (k == 3) begin
      check("b2b_space1", 64'(done_cyc[1] - done_cyc[0]), 64'(W + 2));
      check("b2b_space2", 64'(done_cyc[2] - done_cyc[1]), 64'(W + 2));
    end
    check("b2b_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    // drain the operation accepted while start was still high
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    @(negedge clock);
    check("b2b_drained", 64'(busy | done), 64'd0);
    last_prod = 64'hFFFF_FFFF_FFFF_FFFA;

    // Random signed operand pairs against a 64-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'h8000_0000;
      if (i % 70 == 1) rb = 32'h7FFF_FFFF;
      run_op("rand", ra, rb, ref_mul(ra, rb), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
